// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit beside the execute ALU.
// Shift-add multiplier / restoring divider on operand magnitudes, one bit per
// cycle, followed by a sign-correction cycle and a one-cycle done pulse.
// Build option: define MULDIV_DIV_EN to include the divider; without it the
// divide/remainder ops complete immediately with illegal=1 and result=0.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       cnt_reg;
    logic [2:0]          f3_reg;
    logic                sign_a_reg, sign_b_reg;
    logic                special_reg;
    logic [XLEN-1:0]     op_reg;       // addend (multiply) or divisor (divide) magnitude
    logic [2*XLEN-1:0]   acc_reg;      // product / {remainder, quotient}; holds the bypass value on special ops
    logic [XLEN-1:0]     result_reg;
    logic                illegal_reg;

    // Operand decode at the accept point
    logic            accept, is_div, a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            special;
    logic [XLEN-1:0] special_val;

    assign accept   = start && (state_reg == S_IDLE || state_reg == S_DONE);
    assign is_div   = funct3[2];
    assign a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign neg_a    = a_signed & opA[XLEN-1];
    assign neg_b    = b_signed & opB[XLEN-1];
    assign mag_a    = neg_a ? -opA : opA;
    assign mag_b    = neg_b ? -opB : opB;

`ifdef MULDIV_DIV_EN
    logic div_zero, div_ovf;
    assign div_zero    = is_div && (opB == '0);
    assign div_ovf     = is_div && !funct3[0] && (opA == {1'b1, {(XLEN-1){1'b0}}}) && (opB == '1);
    assign special     = div_zero | div_ovf;
    // REM/REMU (funct3[1]=1) return the remainder, DIV/DIVU the quotient
    assign special_val = div_zero ? (funct3[1] ? opA : '1)
                                  : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
`else
    assign special     = is_div;
    assign special_val = '0;
`endif

    // One iteration step: shift-add for multiply, restoring step for divide
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step, iter_step;

    assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, op_reg} : '0);
    assign mul_step = {mul_sum, acc_reg[XLEN-1:1]};

`ifdef MULDIV_DIV_EN
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] div_step;
    assign div_shift = acc_reg[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, op_reg};
    // A borrow (top bit set) means the divisor did not fit: restore and shift in 0
    assign div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc_reg[XLEN-2:0], 1'b1};
    assign iter_step = f3_reg[2] ? div_step : mul_step;
`else
    assign iter_step = mul_step;
`endif

    // Sign correction and result select for the FIX cycle
    logic              neg_res;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res, fix_res;
    logic              fix_illegal;

    assign neg_res = sign_a_reg ^ sign_b_reg;
    assign prod    = neg_res ? -acc_reg : acc_reg;
    assign mul_res = (f3_reg[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0] quo, rem, div_res;
    assign quo     = acc_reg[XLEN-1:0];
    assign rem     = acc_reg[2*XLEN-1:XLEN];
    // Quotient negated when signs differ; remainder follows the dividend's sign
    assign div_res = f3_reg[1] ? (sign_a_reg ? -rem : rem) : (neg_res ? -quo : quo);
    assign fix_res = special_reg ? acc_reg[XLEN-1:0] : (f3_reg[2] ? div_res : mul_res);
    assign fix_illegal = 1'b0;
`else
    assign fix_res     = special_reg ? acc_reg[XLEN-1:0] : mul_res;
    assign fix_illegal = f3_reg[2];
`endif

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start) state_next = special ? S_FIX : S_ITER;
            S_ITER: if (cnt_reg == LAST_ITER) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: if (start) state_next = special ? S_FIX : S_ITER;
                    else       state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State, operand latches, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            f3_reg      <= '0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            special_reg <= 1'b0;
            op_reg      <= '0;
            acc_reg     <= '0;
            result_reg  <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cnt_reg     <= '0;
                f3_reg      <= funct3;
                sign_a_reg  <= neg_a;
                sign_b_reg  <= neg_b;
                special_reg <= special;
                op_reg      <= is_div ? mag_b : mag_a;
                if (special)
                    acc_reg <= {{XLEN{1'b0}}, special_val};
                else
                    acc_reg <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            end else if (state_reg == S_ITER) begin
                acc_reg <= iter_step;
                cnt_reg <= cnt_reg + 1'b1;
            end else if (state_reg == S_FIX) begin
                result_reg  <= fix_res;
                illegal_reg <= fix_illegal;
            end
        end
    end

    assign busy    = (state_reg == S_ITER) || (state_reg == S_FIX);
    assign done    = (state_reg == S_DONE);
    assign result  = result_reg;
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] opA, opB;
    logic        busy, done, illegal;
    logic [31:0] result;

    int checks = 0;
    int passes = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .opA(opA), .opB(opB), .busy(busy), .done(done),
        .result(result), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) begin
            passes = passes + 1;
        end else begin
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RV32M semantics from 64-bit arithmetic; also the expected done latency
    function automatic void model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        longint      sa, sb, ubl;
        logic [63:0] ua, ub, p;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ubl = longint'(ub);
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        ill = 1'b0;
        lat = 34;
        case (f)
            3'd0: begin p = ua * ub;  r = p[31:0];  end
            3'd1: begin p = sa * sb;  r = p[63:32]; end
            3'd2: begin p = sa * ubl; r = p[63:32]; end
            3'd3: begin p = ua * ub;  r = p[63:32]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 0 || (ovf && !f[0])) lat = 2;
                case (f)
                    3'd4:    r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : ia / ib);
                    3'd5:    r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                    3'd6:    r = (b == 0) ? a : (ovf ? 32'h0 : ia % ib);
                    default: r = (b == 0) ? a : a % b;
                endcase
`else
                lat = 2;
                ill = 1'b1;
                r   = '0;
`endif
            end
        endcase
    endfunction

    // Issue one op at the current cycle T and follow it to done; optionally pulse
    // start with junk operands inside the busy window
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at);
        logic [31:0] er;
        logic        ei;
        int          el, n, lat;
        logic        busy_ok;
        model(f, a, b, er, ei, el);
        start = 1'b1; funct3 = f; opA = a; opB = b;
        @(posedge clk); #1;
        n = 1; lat = 0; busy_ok = 1'b1;
        start = 1'b0; opA = $urandom; opB = $urandom; funct3 = 3'($urandom);
        while (lat == 0 && n <= 60) begin
            if (done === 1'b1) begin
                lat = n;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (n == inject_at) begin
                    start = 1'b1; opA = $urandom; opB = $urandom; funct3 = 3'($urandom);
                end
                @(posedge clk); #1;
                start = 1'b0;
                n++;
            end
        end
        check({tag, " done latency"}, 32'(lat), 32'(el));
        check({tag, " busy in flight"}, {31'b0, busy_ok}, 32'd1);
        check({tag, " busy at done"}, {31'b0, busy}, 32'd0);
        check({tag, " result"}, result, er);
        check({tag, " illegal"}, {31'b0, illegal}, {31'b0, ei});
        $display("op %-14s f3=%0d a=%h b=%h -> result=%h illegal=%0b latency=%0d (exp %h/%0b/%0d)",
                 tag, f, a, b, result, illegal, lat, er, ei, el);
    endtask

    // Abort a divide with reset at T+10 and confirm no done follows
    task automatic run_reset();
        logic saw_done;
        start = 1'b1; funct3 = 3'd4; opA = 32'd1000; opB = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset-abort busy", {31'b0, busy}, 32'd0);
        check("reset-abort done", {31'b0, done}, 32'd0);
        check("reset-abort result", result, 32'd0);
        check("reset-abort illegal", {31'b0, illegal}, 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check("reset-abort no done", {31'b0, saw_done}, 32'd0);
        $display("op reset-abort  DIV 1000/7 reset at T+10 -> busy=%0b result=%h done_seen=%0b",
                 busy, result, saw_done);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; funct3 = '0; opA = '0; opB = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset illegal", {31'b0, illegal}, 32'd0);

        run_op("MUL 7*-3",       3'd0, 32'd7,          32'hFFFF_FFFD, 0);
        run_op("MULHU -1*-1",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
        run_op("MULH -1*-1",     3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
        run_op("MULHSU -1*2",    3'd2, 32'hFFFF_FFFF,  32'd2,         0);
        run_op("DIV -7/2",       3'd4, 32'hFFFF_FFF9,  32'd2,         0);
        run_op("REM -7/2",       3'd6, 32'hFFFF_FFF9,  32'd2,         0);
        run_op("DIVU 100/7",     3'd5, 32'd100,        32'd7,         0);
        run_op("REMU 100/7",     3'd7, 32'd100,        32'd7,         0);
        run_op("DIVU 5/0",       3'd5, 32'd5,          32'd0,         0);
        run_op("REM 5/0",        3'd6, 32'd5,          32'd0,         0);
        run_op("DIV ovf",        3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        run_op("REM ovf",        3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        run_op("DIV 8/2",        3'd4, 32'd8,          32'd2,         0);
        run_op("MUL 3*4",        3'd0, 32'd3,          32'd4,         0);
        run_op("MUL ignore-st",  3'd0, 32'h1234_5678,  32'h9ABC_DEF1, 5);
        run_reset();
        run_op("MUL after rst",  3'd0, 32'd3,          32'd4,         0);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
                3: begin ra = -$urandom_range(0, 300); rb = $urandom_range(1, 20); end
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), rf, ra, rb, 0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
